// File: rtl/seven_segment_scanner.sv
// Time-multiplexed scanner for a multi-digit seven-segment display.
// Double-buffered value commits at frame boundaries; per-slot dead time avoids ghosting.
module seven_segment_scanner #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 1200,
    parameter int unsigned BLANK    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  lz_blank,
    input  logic                  load,
    output logic                  load_ready,
    output logic [3:0]            nibble,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_start
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] active_value;
    logic [DIGITS-1:0]   active_dp;
    logic [4*DIGITS-1:0] pending_value;
    logic [DIGITS-1:0]   pending_dp;
    logic                pending_valid;

    logic                slot_end;
    logic                frame_end;
    logic                accept;
    logic [DIGITS-1:0]   suppressed;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign accept    = load && !pending_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            idx           <= '0;
            active_value  <= '0;
            active_dp     <= '0;
            pending_value <= '0;
            pending_dp    <= '0;
            pending_valid <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + CW'(1);
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end
            // Commit and accept are mutually exclusive: accept needs an empty pending buffer.
            if (frame_end && pending_valid) begin
                active_value  <= pending_value;
                active_dp     <= pending_dp;
                pending_valid <= 1'b0;
            end
            if (accept) begin
                pending_value <= value;
                pending_dp    <= dp;
                pending_valid <= 1'b1;
            end
        end
    end

    // Walk from the most significant digit down, tracking whether everything above is blank.
    always_comb begin
        logic run_zero;
        run_zero   = 1'b1;
        suppressed = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            run_zero = run_zero
                       && (active_value[4*(DIGITS-1-k) +: 4] == 4'h0)
                       && !active_dp[DIGITS-1-k];
            suppressed[DIGITS-1-k] = lz_blank && run_zero && (k != DIGITS - 1);
        end
    end

    always_comb begin
        load_ready  = 1'b0;
        nibble      = '0;
        dp_out      = 1'b0;
        digit_en    = '0;
        frame_start = 1'b0;
        if (!rst) begin
            load_ready  = !pending_valid;
            nibble      = active_value[4*idx +: 4];
            frame_start = (idx == '0) && (cnt == '0);
            if ((cnt >= CNT_BLANK) && !suppressed[idx]) begin
                digit_en = DIGITS'(1) << idx;
            end
            dp_out = (digit_en != '0) && active_dp[idx];
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner: directed scenarios plus
// randomized traffic compared against a frame-level reference model.
module tb_seven_segment_scanner;

    localparam int D = 4;
    localparam int P = 8;
    localparam int B = 2;
    localparam int F = D * P;

    logic          clk;
    logic          rst;
    logic [15:0]   value;
    logic [3:0]    dp;
    logic          lz_blank;
    logic          load;
    logic          load_ready;
    logic [3:0]    nibble;
    logic          dp_out;
    logic [3:0]    digit_en;
    logic          frame_start;

    int checks;
    int failures;

    // Reference model: time since reset plus displayed and pending buffers.
    int          m_t;
    logic [15:0] m_act;
    logic [3:0]  m_adp;
    logic [15:0] m_pend;
    logic [3:0]  m_pdp;
    bit          m_pv;

    seven_segment_scanner #(
        .DIGITS(D),
        .PRESCALE(P),
        .BLANK(B)
    ) dut (
        .clk(clk),
        .rst(rst),
        .value(value),
        .dp(dp),
        .lz_blank(lz_blank),
        .load(load),
        .load_ready(load_ready),
        .nibble(nibble),
        .dp_out(dp_out),
        .digit_en(digit_en),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        bit acc;
        if (rst) begin
            m_t = 0; m_act = '0; m_adp = '0; m_pend = '0; m_pdp = '0; m_pv = 0;
        end else begin
            acc = load && !m_pv;
            if ((m_t % F) == F - 1 && m_pv) begin
                m_act = m_pend; m_adp = m_pdp; m_pv = 0;
            end
            if (acc) begin
                m_pend = value; m_pdp = dp; m_pv = 1;
            end
            m_t++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_outputs(output logic [3:0] e_nib, output logic [3:0] e_en,
                                 output logic e_dp, output logic e_fs, output logic e_lr);
        int slot, d;
        logic [15:0] upper;
        logic [3:0]  upper_dp;
        bit supp;
        e_nib = '0; e_en = '0; e_dp = 0; e_fs = 0; e_lr = 0;
        if (!rst) begin
            slot     = m_t % P;
            d        = (m_t / P) % D;
            upper    = m_act >> (4 * d);
            upper_dp = m_adp >> d;
            e_nib    = upper[3:0];
            supp     = lz_blank && d > 0 && upper == 16'h0 && upper_dp == 4'h0;
            e_en     = (slot >= B && !supp) ? 4'(1 << d) : 4'b0;
            e_dp     = (e_en != 4'b0) && m_adp[d];
            e_fs     = (m_t % F) == 0;
            e_lr     = !m_pv;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        load = 1'b0;
        repeat (n) cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_en;
        rst = 1'b1; load = 1'b0; lz_blank = 1'b0;
        for (int i = 0; i < 3; i++) begin
            value = 16'($urandom); dp = 4'($urandom); load = 1'b1;
            #1;
            checks++;
            if ({nibble, digit_en, dp_out, frame_start, load_ready} !== 11'b0) begin
                failures++;
                $display("FAIL reset_outputs i=%0d got=%b exp=0", i,
                         {nibble, digit_en, dp_out, frame_start, load_ready});
            end
            cycle();
        end
        rst = 1'b0; load = 1'b0;
        for (int c = 0; c <= 40; c++) begin
            #1;
            exp_en = ((c % P) >= B) ? 4'(1 << ((c / P) % D)) : 4'b0;
            checks++;
            if (digit_en !== exp_en) begin
                failures++;
                $display("FAIL release_digit_en c=%0d got=%b exp=%b", c, digit_en, exp_en);
            end
            checks++;
            if (frame_start !== ((c % F) == 0)) begin
                failures++;
                $display("FAIL release_frame_start c=%0d got=%b exp=%b", c, frame_start, (c % F) == 0);
            end
            checks++;
            if (load_ready !== 1'b1) begin
                failures++;
                $display("FAIL release_load_ready c=%0d got=%b exp=1", c, load_ready);
            end
            cycle();
        end
    endtask

    task automatic test_load_commit();
        logic [15:0] tmp;
        logic [3:0]  exp_nib;
        logic        exp_lr, exp_dp;
        lz_blank = 1'b0;
        do_reset(2);
        for (int c = 0; c < 64; c++) begin
            load  = (c == 5);
            value = (c == 5) ? 16'h1234 : 16'($urandom);
            dp    = (c == 5) ? 4'b0100 : 4'($urandom);
            #1;
            tmp     = 16'h1234 >> (4 * ((c / P) % D));
            exp_nib = (c < 32) ? 4'h0 : tmp[3:0];
            exp_lr  = (c < 6) || (c >= 32);
            exp_dp  = (c >= 50) && (c <= 55);
            checks++;
            if (nibble !== exp_nib) begin
                failures++;
                $display("FAIL commit_nibble c=%0d got=%h exp=%h", c, nibble, exp_nib);
            end
            checks++;
            if (load_ready !== exp_lr) begin
                failures++;
                $display("FAIL commit_load_ready c=%0d got=%b exp=%b", c, load_ready, exp_lr);
            end
            checks++;
            if (dp_out !== exp_dp) begin
                failures++;
                $display("FAIL commit_dp_out c=%0d got=%b exp=%b", c, dp_out, exp_dp);
            end
            cycle();
        end
        load = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_nib;
        logic       exp_lr;
        lz_blank = 1'b0;
        do_reset(2);
        for (int c = 0; c < 96; c++) begin
            load  = (c == 3) || (c == 4);
            value = (c == 3) ? 16'h1111 : (c == 4) ? 16'h2222 : 16'($urandom);
            dp    = 4'b0;
            #1;
            exp_nib = (c < 32) ? 4'h0 : 4'h1;
            exp_lr  = (c < 4) || (c >= 32);
            checks++;
            if (nibble !== exp_nib) begin
                failures++;
                $display("FAIL b2b_nibble c=%0d got=%h exp=%h", c, nibble, exp_nib);
            end
            checks++;
            if (load_ready !== exp_lr) begin
                failures++;
                $display("FAIL b2b_load_ready c=%0d got=%b exp=%b", c, load_ready, exp_lr);
            end
            cycle();
        end
        load = 1'b0;
    endtask

    task automatic test_lz();
        logic [15:0] lv [3];
        logic [3:0]  ldp [3];
        logic [3:0]  lmask [3];
        logic [3:0]  mask, exp_en;
        logic        exp_dp;
        int          d, slot;
        lv    = '{16'h0050, 16'h0000, 16'h0000};
        ldp   = '{4'b0000, 4'b0000, 4'b1000};
        lmask = '{4'b0011, 4'b0001, 4'b1111};
        for (int k = 0; k < 3; k++) begin
            lz_blank = 1'b1;
            do_reset(2);
            for (int c = 0; c < 64; c++) begin
                load = (c == 0); value = lv[k]; dp = ldp[k];
                #1;
                d      = (c / P) % D;
                slot   = c % P;
                mask   = (c < 32) ? 4'b0001 : lmask[k];
                exp_en = (slot >= B && mask[d]) ? 4'(1 << d) : 4'b0;
                exp_dp = (c >= 32) && ldp[k][d] && (slot >= B);
                checks++;
                if (digit_en !== exp_en) begin
                    failures++;
                    $display("FAIL lz_digit_en case=%0d c=%0d got=%b exp=%b", k, c, digit_en, exp_en);
                end
                checks++;
                if (dp_out !== exp_dp) begin
                    failures++;
                    $display("FAIL lz_dp_out case=%0d c=%0d got=%b exp=%b", k, c, dp_out, exp_dp);
                end
                cycle();
            end
        end
        load = 1'b0; lz_blank = 1'b0;
    endtask

    task automatic test_last_cycle();
        logic [15:0] tmp;
        logic [3:0]  exp_nib;
        logic        exp_lr;
        lz_blank = 1'b0;
        do_reset(2);
        for (int c = 0; c < 96; c++) begin
            load  = (c == 31);
            value = (c == 31) ? 16'hABCD : 16'($urandom);
            dp    = 4'b0;
            #1;
            tmp     = 16'hABCD >> (4 * ((c / P) % D));
            exp_nib = (c < 64) ? 4'h0 : tmp[3:0];
            exp_lr  = (c < 32) || (c >= 64);
            checks++;
            if (nibble !== exp_nib) begin
                failures++;
                $display("FAIL last_nibble c=%0d got=%h exp=%h", c, nibble, exp_nib);
            end
            checks++;
            if (load_ready !== exp_lr) begin
                failures++;
                $display("FAIL last_load_ready c=%0d got=%b exp=%b", c, load_ready, exp_lr);
            end
            cycle();
        end
        load = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_en;
        lz_blank = 1'b0;
        do_reset(2);
        for (int c = 0; c < 20; c++) begin
            load  = (c == 2);
            value = 16'h9876;
            dp    = 4'b1111;
            #1;
            checks++;
            if (load_ready !== (c < 3)) begin
                failures++;
                $display("FAIL mid_load_ready c=%0d got=%b exp=%b", c, load_ready, c < 3);
            end
            cycle();
        end
        rst = 1'b1; load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({nibble, digit_en, dp_out, frame_start, load_ready} !== 11'b0) begin
                failures++;
                $display("FAIL mid_reset_outputs i=%0d got=%b exp=0", i,
                         {nibble, digit_en, dp_out, frame_start, load_ready});
            end
            cycle();
        end
        rst = 1'b0;
        for (int c = 0; c < 96; c++) begin
            #1;
            exp_en = ((c % P) >= B) ? 4'(1 << ((c / P) % D)) : 4'b0;
            checks++;
            if ({nibble, dp_out, load_ready} !== 6'b000001) begin
                failures++;
                $display("FAIL mid_discard c=%0d got nib=%h dp=%b rdy=%b exp nib=0 dp=0 rdy=1",
                         c, nibble, dp_out, load_ready);
            end
            checks++;
            if (digit_en !== exp_en) begin
                failures++;
                $display("FAIL mid_digit_en c=%0d got=%b exp=%b", c, digit_en, exp_en);
            end
            checks++;
            if (frame_start !== ((c % F) == 0)) begin
                failures++;
                $display("FAIL mid_frame_start c=%0d got=%b exp=%b", c, frame_start, (c % F) == 0);
            end
            cycle();
        end
    endtask

    task automatic test_random();
        logic [3:0] e_nib, e_en;
        logic       e_dp, e_fs, e_lr;
        lz_blank = 1'b0;
        do_reset(2);
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom % 300) == 0;
            load  = (($urandom % 6) == 0) || (((m_t % F) == F - 1) && ($urandom % 2 == 1));
            value = 16'($urandom);
            dp    = 4'($urandom);
            if ($urandom % 2 == 1) begin
                value = value >> (4 * ($urandom % 4));
                dp    = dp >> ($urandom % 5);
            end
            if ($urandom % 40 == 0) lz_blank = ~lz_blank;
            #1;
            model_outputs(e_nib, e_en, e_dp, e_fs, e_lr);
            checks++;
            if (nibble !== e_nib) begin
                failures++;
                $display("FAIL rand_nibble n=%0d got=%h exp=%h", n, nibble, e_nib);
            end
            checks++;
            if (digit_en !== e_en) begin
                failures++;
                $display("FAIL rand_digit_en n=%0d got=%b exp=%b", n, digit_en, e_en);
            end
            checks++;
            if (dp_out !== e_dp) begin
                failures++;
                $display("FAIL rand_dp_out n=%0d got=%b exp=%b", n, dp_out, e_dp);
            end
            checks++;
            if (frame_start !== e_fs) begin
                failures++;
                $display("FAIL rand_frame_start n=%0d got=%b exp=%b", n, frame_start, e_fs);
            end
            checks++;
            if (load_ready !== e_lr) begin
                failures++;
                $display("FAIL rand_load_ready n=%0d got=%b exp=%b", n, load_ready, e_lr);
            end
            cycle();
        end
        rst = 1'b0; load = 1'b0; lz_blank = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        load     = 1'b0;
        lz_blank = 1'b0;
        value    = '0;
        dp       = '0;
        m_t = 0; m_act = '0; m_adp = '0; m_pend = '0; m_pdp = '0; m_pv = 0;
        test_reset();
        test_load_commit();
        test_back_to_back();
        test_lz();
        test_last_cycle();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
